// File: rtl/csr_access_unit_pkg.sv
// Shared constants and types for the CSR access unit: Zicsr funct3 codes,
// FSM state encoding and the read-only CSR address field value.
package csr_access_unit_pkg;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    localparam logic [1:0] RO_FIELD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // RS/RC and their immediate forms always read the CSR (funct3[1] set)
    function automatic logic is_set_clear(input logic [2:0] funct3);
        return funct3[1];
    endfunction

    function automatic logic is_bad_op(input logic [2:0] funct3);
        return funct3[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// Combinational new-value computation for the CSR read-modify-write.
import csr_access_unit_pkg::*;

module csr_alu #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] new_value
);

    // funct3[1:0] selects the operation for both register and immediate forms
    always_comb begin
        new_value = '0;
        case (funct3[1:0])
            CSR_RW[1:0]: new_value = operand;
            CSR_RS[1:0]: new_value = old | operand;
            CSR_RC[1:0]: new_value = old & ~operand;
            default:     new_value = '0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR port: sequences one Zicsr read-modify-write at a
// time against a combinational-read / registered-write CSR file.
import csr_access_unit_pkg::*;

module csr_access_unit #(
    parameter int          XLEN     = 32,
    parameter int          CSR_AW   = 12,
    parameter int unsigned RO_CHECK = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [CSR_AW-1:0] req_csr_addr,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [4:0]        req_rs1_idx,
    input  logic [4:0]        req_rd_idx,
    input  logic              flush,
    output logic              busy,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd_idx,
    output logic              resp_illegal,
    output logic [CSR_AW-1:0] csr_addr,
    output logic              csr_ren,
    output logic              csr_wen,
    output logic [XLEN-1:0]   csr_wd,
    input  logic [XLEN-1:0]   csr_rd
);

    state_t state, state_next;

    logic [2:0]        funct3_q;
    logic [CSR_AW-1:0] addr_q;
    logic [4:0]        rd_idx_q;
    logic [XLEN-1:0]   operand_q;
    logic [XLEN-1:0]   old_q;
    logic              need_write_q;
    logic              bad_op_q;
    logic              ro_viol_q;

    logic              accept;
    logic [XLEN-1:0]   in_operand;
    logic              in_need_read;
    logic              in_need_write;
    logic              in_bad_op;
    logic              in_ro_viol;
    logic [XLEN-1:0]   alu_value;

    // Decode of the incoming request, only meaningful while accepting
    always_comb begin
        accept        = (state == ST_IDLE) && req_valid && !flush;
        in_operand    = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_data;
        in_need_read  = is_set_clear(req_funct3) || (req_rd_idx != 5'd0);
        in_need_write = (req_funct3[1:0] == CSR_RW[1:0]) || (req_rs1_idx != 5'd0);
        in_bad_op     = is_bad_op(req_funct3);
        in_ro_viol    = (RO_CHECK != 0) && in_need_write &&
                        (req_csr_addr[CSR_AW-1 -: 2] == RO_FIELD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture registers; old value is cleared on accept so unread ops return 0
    always_ff @(posedge clock) begin
        if (reset) begin
            funct3_q     <= 3'd0;
            addr_q       <= '0;
            rd_idx_q     <= 5'd0;
            operand_q    <= '0;
            old_q        <= '0;
            need_write_q <= 1'b0;
            bad_op_q     <= 1'b0;
            ro_viol_q    <= 1'b0;
        end else if (accept) begin
            funct3_q     <= req_funct3;
            addr_q       <= req_csr_addr;
            rd_idx_q     <= req_rd_idx;
            operand_q    <= in_operand;
            old_q        <= '0;
            need_write_q <= in_need_write;
            bad_op_q     <= in_bad_op;
            ro_viol_q    <= in_ro_viol;
        end else if (state == ST_READ) begin
            old_q        <= csr_rd;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (in_bad_op)
                        state_next = ST_RESP;
                    else if (in_need_read)
                        state_next = ST_READ;
                    else if (in_ro_viol)
                        state_next = ST_RESP;
                    else
                        state_next = ST_WRITE;
                end
            end
            ST_READ: begin
                if (flush)
                    state_next = ST_IDLE;
                else if (need_write_q && !ro_viol_q)
                    state_next = ST_WRITE;
                else
                    state_next = ST_RESP;
            end
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    csr_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .funct3   (funct3_q),
        .old      (old_q),
        .operand  (operand_q),
        .new_value(alu_value)
    );

    // Moore outputs decoded from state and capture registers
    always_comb begin
        req_ready    = (state == ST_IDLE);
        busy         = (state != ST_IDLE);
        csr_addr     = (state != ST_IDLE) ? addr_q : '0;
        csr_ren      = (state == ST_READ);
        csr_wen      = (state == ST_WRITE);
        csr_wd       = (state == ST_WRITE) ? alu_value : '0;
        resp_valid   = (state == ST_RESP);
        resp_data    = (state == ST_RESP) ? old_q : '0;
        resp_rd_idx  = (state == ST_RESP) ? rd_idx_q : 5'd0;
        resp_illegal = (state == ST_RESP) && (bad_op_q || ro_viol_q);
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit with a behavioural CSR file
// that forces read data to zero while write-enable is high.
module tb_csr_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rs1_idx;
    logic [4:0]  req_rd_idx;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd_idx;
    logic        resp_illegal;
    logic [11:0] csr_addr;
    logic        csr_ren;
    logic        csr_wen;
    logic [31:0] csr_wd;
    logic [31:0] csr_rd;

    logic [31:0] csr_mem [0:4095];

    int errors = 0;
    int checks = 0;

    int          lat;
    logic        saw_ren;
    logic        saw_wen;
    logic [31:0] wd_seen;
    logic [31:0] data_seen;
    logic        ill_seen;
    logic [4:0]  rd_seen;

    always #5 clock = ~clock;

    csr_access_unit dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_csr_addr(req_csr_addr),
        .req_rs1_data(req_rs1_data),
        .req_rs1_idx (req_rs1_idx),
        .req_rd_idx  (req_rd_idx),
        .flush       (flush),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_rd_idx (resp_rd_idx),
        .resp_illegal(resp_illegal),
        .csr_addr    (csr_addr),
        .csr_ren     (csr_ren),
        .csr_wen     (csr_wen),
        .csr_wd      (csr_wd),
        .csr_rd      (csr_rd)
    );

    // CSR file model: combinational read gated off by wen, registered write
    assign csr_rd = csr_wen ? 32'd0 : csr_mem[csr_addr];

    always @(posedge clock) begin
        if (csr_wen)
            csr_mem[csr_addr] <= csr_wd;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request, then watches five cycles recording strobes and the response
    task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                                 input logic [4:0] rs1, input logic [4:0] rd, input int flush_cyc);
        lat = 0; saw_ren = 0; saw_wen = 0; wd_seen = 0;
        data_seen = 0; ill_seen = 0; rd_seen = 0;
        @(negedge clock);
        checkOutput("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_funct3 = f3; req_csr_addr = a;
        req_rs1_data = d; req_rs1_idx = rs1; req_rd_idx = rd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clock);
            if (csr_ren) saw_ren = 1'b1;
            if (csr_wen) begin
                saw_wen = 1'b1;
                wd_seen = csr_wd;
            end
            if (resp_valid && lat == 0) begin
                lat       = cyc;
                data_seen = resp_data;
                ill_seen  = resp_illegal;
                rd_seen   = resp_rd_idx;
            end
            flush = (cyc == flush_cyc);
        end
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_csr_addr = 12'd0;
        req_rs1_data = 32'd0; req_rs1_idx = 5'd0; req_rd_idx = 5'd0; flush = 1'b0;
        for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_strobes", {30'd0, csr_ren, csr_wen}, 32'd0);
        checkOutput("rst_addr", {20'd0, csr_addr}, 32'd0);
        checkOutput("rst_wd", csr_wd, 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        reset = 1'b0;

        // CSRRS read-only
        csr_mem[12'h300] <= 32'h0000_1888;
        applyStimulus(3'b010, 12'h300, 32'd0, 5'd0, 5'd5, -1);
        checkOutput("rs_lat", lat, 32'd2);
        checkOutput("rs_strobes", {30'd0, saw_ren, saw_wen}, 32'b10);
        checkOutput("rs_data", data_seen, 32'h0000_1888);
        checkOutput("rs_rd", {27'd0, rd_seen}, 32'd5);
        checkOutput("rs_illegal", {31'd0, ill_seen}, 32'd0);

        // CSRRC full RMW
        csr_mem[12'h300] <= 32'h88;
        applyStimulus(3'b011, 12'h300, 32'h8, 5'd2, 5'd1, -1);
        checkOutput("rc_lat", lat, 32'd3);
        checkOutput("rc_wd", wd_seen, 32'h80);
        checkOutput("rc_data", data_seen, 32'h88);
        checkOutput("rc_mem", csr_mem[12'h300], 32'h80);

        // CSRRWI write-only
        applyStimulus(3'b101, 12'h340, 32'hDEAD_BEEF, 5'd5, 5'd0, -1);
        checkOutput("rwi_lat", lat, 32'd2);
        checkOutput("rwi_strobes", {30'd0, saw_ren, saw_wen}, 32'b01);
        checkOutput("rwi_wd", wd_seen, 32'h5);
        checkOutput("rwi_data", data_seen, 32'd0);
        checkOutput("rwi_mem", csr_mem[12'h340], 32'h5);

        // CSRRW to read-only CSR: read happens, write suppressed
        csr_mem[12'hC00] <= 32'h1234;
        applyStimulus(3'b001, 12'hC00, 32'h1, 5'd1, 5'd3, -1);
        checkOutput("ro_lat", lat, 32'd2);
        checkOutput("ro_strobes", {30'd0, saw_ren, saw_wen}, 32'b10);
        checkOutput("ro_illegal", {31'd0, ill_seen}, 32'd1);
        checkOutput("ro_data", data_seen, 32'h1234);
        checkOutput("ro_mem", csr_mem[12'hC00], 32'h1234);

        // Reserved funct3
        applyStimulus(3'b100, 12'h300, 32'hFF, 5'd1, 5'd1, -1);
        checkOutput("bad_lat", lat, 32'd1);
        checkOutput("bad_strobes", {30'd0, saw_ren, saw_wen}, 32'b00);
        checkOutput("bad_illegal", {31'd0, ill_seen}, 32'd1);
        checkOutput("bad_data", data_seen, 32'd0);

        // Write-only to read-only CSR: immediate illegal response
        applyStimulus(3'b101, 12'hC01, 32'd0, 5'd3, 5'd0, -1);
        checkOutput("rowi_lat", lat, 32'd1);
        checkOutput("rowi_strobes", {30'd0, saw_ren, saw_wen}, 32'b00);
        checkOutput("rowi_illegal", {31'd0, ill_seen}, 32'd1);

        // CSRRCI with uimm=0 reads without writing
        applyStimulus(3'b111, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd0, -1);
        checkOutput("rci0_lat", lat, 32'd2);
        checkOutput("rci0_strobes", {30'd0, saw_ren, saw_wen}, 32'b10);
        checkOutput("rci0_data", data_seen, 32'h80);

        // CSRRSI full RMW with zero-extended uimm
        csr_mem[12'h341] <= 32'hFFFF_FF00;
        applyStimulus(3'b110, 12'h341, 32'h0, 5'h1F, 5'd4, -1);
        checkOutput("rsi_lat", lat, 32'd3);
        checkOutput("rsi_wd", wd_seen, 32'hFFFF_FF1F);
        checkOutput("rsi_data", data_seen, 32'hFFFF_FF00);

        // Flush during READ abandons the access
        csr_mem[12'h305] <= 32'h100;
        applyStimulus(3'b010, 12'h305, 32'hF0, 5'd3, 5'd2, 1);
        checkOutput("flr_resp", lat, 32'd0);
        checkOutput("flr_wen", {31'd0, saw_wen}, 32'd0);
        checkOutput("flr_mem", csr_mem[12'h305], 32'h100);
        checkOutput("flr_idle", {31'd0, req_ready}, 32'd1);

        // Flush during WRITE is ignored
        applyStimulus(3'b010, 12'h305, 32'hF0, 5'd3, 5'd2, 2);
        checkOutput("flw_lat", lat, 32'd3);
        checkOutput("flw_wd", wd_seen, 32'h1F0);
        checkOutput("flw_data", data_seen, 32'h100);
        checkOutput("flw_mem", csr_mem[12'h305], 32'h1F0);

        // Flush in IDLE blocks accept
        @(negedge clock);
        req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340;
        req_rs1_idx = 5'd1; req_rd_idx = 5'd1;
        @(negedge clock);
        checkOutput("fli_busy", {31'd0, busy}, 32'd0);
        req_valid = 1'b0; flush = 1'b0;

        // Back-to-back CSRRW, reset during the second one's READ
        csr_mem[12'h342] <= 32'h77;
        @(negedge clock);
        req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340;
        req_rs1_data = 32'hAA; req_rs1_idx = 5'd1; req_rd_idx = 5'd1;
        @(posedge clock);
        #1 req_csr_addr = 12'h342; req_rs1_data = 32'hBB; req_rs1_idx = 5'd2; req_rd_idx = 5'd2;
        @(negedge clock);
        checkOutput("b2b_read1", {20'd0, csr_addr}, {20'd0, 12'h340});
        checkOutput("b2b_ready_busy", {31'd0, req_ready}, 32'd0);
        @(negedge clock);
        checkOutput("b2b_wen1", {31'd0, csr_wen}, 32'd1);
        checkOutput("b2b_wd1", csr_wd, 32'hAA);
        @(negedge clock);
        checkOutput("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        checkOutput("b2b_rd1", {27'd0, resp_rd_idx}, 32'd1);
        checkOutput("b2b_data1", resp_data, 32'h5);
        @(negedge clock);
        checkOutput("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        checkOutput("b2b_read2", {31'd0, csr_ren}, 32'd1);
        checkOutput("b2b_addr2", {20'd0, csr_addr}, {20'd0, 12'h342});
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clock);
        checkOutput("b2b_rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("b2b_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("b2b_no_wen", {31'd0, csr_wen}, 32'd0);
        end
        checkOutput("b2b_mem1", csr_mem[12'h340], 32'hAA);
        checkOutput("b2b_mem2", csr_mem[12'h342], 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
